// File: rtl/pro_bin_pack.sv
// Threshold binarizer and bit packer with output FIFO for XNOR-popcount PEs.
// Optional macro PRO_BN_FLIP_EN adds a per-channel flipped (<=) compare.
module pro_bin_pack #(
  parameter int PAR        = 16,
  parameter int WIDTH      = 9,
  parameter int OUT_CH     = 128,
  parameter int PACK_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PAR*WIDTH-1:0]       in_data,
  input  logic                       thr_we,
  input  logic [$clog2(OUT_CH)-1:0]  thr_addr,
  input  logic [WIDTH-1:0]           thr_data,
`ifdef PRO_BN_FLIP_EN
  input  logic                       thr_flip,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK_W-1:0]          out_data,
  output logic                       out_last
);

  localparam int GRPS  = PACK_W / PAR;
  localparam int GW    = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int WORDS = OUT_CH / PACK_W;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = $clog2(OUT_CH);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [GW-1:0] GRP_LAST  = GW'(GRPS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  logic [GW-1:0]     grp_cnt_q, grp_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;

  logic signed [WIDTH-1:0] thr_q [OUT_CH];
`ifdef PRO_BN_FLIP_EN
  logic                    flip_q [OUT_CH];
`endif
  logic [PACK_W:0]         mem_q [FIFO_DEPTH];

  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              grp_end;
  logic              push;
  logic              pop;
  logic              word_last;
  logic [PAR-1:0]    lane_bits;
  logic [PACK_W-1:0] word_bits;

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    logic [CW-1:0]           ch;
    logic signed [WIDTH-1:0] lane;
    logic signed [WIDTH-1:0] thr;
    assign ch   = CW'(32'(word_cnt_q) * PACK_W
                  + 32'(grp_cnt_q) * PAR + i);
    assign lane = in_data[i*WIDTH +: WIDTH];
    assign thr  = thr_q[ch];
`ifdef PRO_BN_FLIP_EN
    assign lane_bits[i] = flip_q[ch] ? (lane <= thr)
                                     : (lane >= thr);
`else
    assign lane_bits[i] = (lane >= thr);
`endif
  end

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign grp_end    = (grp_cnt_q == GRP_LAST);
  assign word_last  = (word_cnt_q == WORD_LAST);

  // Pack register is cleared per word, so OR-ing the new group is exact.
  assign word_bits = pack_q |
    (PACK_W'(lane_bits) << (32'(grp_cnt_q) * PAR));

  assign accept = in_valid && in_ready;
  assign push   = accept && grp_end && !clr;
  assign pop    = out_valid && out_ready && !clr;

  always_comb begin
    in_ready  = !(fifo_full && grp_end);
    out_valid = !fifo_empty;
    out_data  = '0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      out_data = mem_q[rptr_q[AW-1:0]][PACK_W:1];
      out_last = mem_q[rptr_q[AW-1:0]][0];
    end
  end

  always_comb begin
    grp_cnt_d  = grp_cnt_q;
    word_cnt_d = word_cnt_q;
    pack_d     = pack_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (clr) begin
      grp_cnt_d  = '0;
      word_cnt_d = '0;
      pack_d     = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (accept) begin
        if (grp_end) begin
          grp_cnt_d  = '0;
          pack_d     = '0;
          wptr_d     = wptr_q + PTR_ONE;
          word_cnt_d = word_last ? '0 : word_cnt_q + WW'(1);
        end else begin
          grp_cnt_d = grp_cnt_q + GW'(1);
          pack_d    = word_bits;
        end
      end
      if (pop) rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grp_cnt_q  <= '0;
      word_cnt_q <= '0;
      pack_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      grp_cnt_q  <= grp_cnt_d;
      word_cnt_q <= word_cnt_d;
      pack_q     <= pack_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push)
      mem_q[wptr_q[AW-1:0]] <= {word_bits, word_last};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < OUT_CH; k++) thr_q[k] <= '0;
    end else if (thr_we) begin
      thr_q[thr_addr] <= thr_data;
    end
  end

`ifdef PRO_BN_FLIP_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < OUT_CH; k++) flip_q[k] <= 1'b0;
    end else if (thr_we) begin
      flip_q[thr_addr] <= thr_flip;
    end
  end
`endif

endmodule
